result_avg: RTL

- Downstream stage of the per-window peak counter.
- When a measurement window closes (en falls), the block waits for the counter's sum/count outputs to settle, then latches them.
- It computes the average peak spacing, sum / s, with a serial restoring divider and an optional round-half-up step.
- It converts the average and the peak count to 3-digit BCD for the display driver, then pulses done.

---
 rtl/result_avg_if.sv | 34 +++
 rtl/result_avg.sv | 162 ++++++++++++++++
 2 files changed

// File: rtl/result_avg_if.sv
// Bundles the window-control inputs and the result outputs of result_avg.
//   en       : measurement enable; a 1->0 transition closes a window
//   sum_in   : accumulated peak-spacing sum from the upstream counter
//   s_in     : peak count from the upstream counter
//   avg_bin  : average spacing, binary
//   avg_bcd  : average spacing, BCD hundreds/tens/units
//   cnt_bcd  : peak count, BCD hundreds/tens/units
//   div0     : latched peak count was zero
//   busy     : a window is being processed
//   done     : one-cycle pulse when the outputs update
interface result_avg_if;
    localparam int unsigned DW = 8;
    localparam int unsigned BW = 12;

    logic          en;
    logic [DW-1:0] sum_in;
    logic [DW-1:0] s_in;
    logic [DW-1:0] avg_bin;
    logic [BW-1:0] avg_bcd;
    logic [BW-1:0] cnt_bcd;
    logic          div0;
    logic          busy;
    logic          done;

    modport master (
        output en, sum_in, s_in,
        input  avg_bin, avg_bcd, cnt_bcd, div0, busy, done
    );

    modport slave (
        input  en, sum_in, s_in,
        output avg_bin, avg_bcd, cnt_bcd, div0, busy, done
    );
endinterface

// File: rtl/result_avg.sv
// Averages the per-window peak spacing: on window close, waits SETTLE cycles,
// latches sum/count, divides serially (restoring, optional round half up),
// converts average and count to BCD, then updates outputs with a done pulse.
//   clk, rst_n : clock and asynchronous active-low reset
//   bus        : result_avg_if slave (en, sum_in, s_in in; results, busy, done out)
module result_avg #(
    parameter int unsigned SETTLE = 2,
    parameter bit          ROUND  = 1'b1
) (
    input  logic        clk,
    input  logic        rst_n,
    result_avg_if.slave bus
);
    localparam int unsigned DW    = 8;
    localparam int unsigned BW    = 12;
    localparam int unsigned SHW   = BW + DW;
    localparam int unsigned CNT_W = ($clog2(SETTLE) > 3) ? $clog2(SETTLE) : 3;
    localparam logic [CNT_W-1:0] SETTLE_LAST = CNT_W'(SETTLE - 1);
    localparam logic [CNT_W-1:0] STEP_LAST   = CNT_W'(DW - 1);

    typedef enum logic [2:0] {S_IDLE, S_WAIT, S_DIV, S_BCD, S_DONE} state_t;

    state_t           state_q, state_d;
    logic             en_d;
    logic [CNT_W-1:0] cnt_q;
    logic [DW-1:0]    dvd_q;      // dividend bits shift out MSB first, quotient bits shift in
    logic [DW-1:0]    dvs_q;
    logic [DW-1:0]    rem_q;
    logic [DW-1:0]    q_q;
    logic             div0_q;
    logic [SHW-1:0]   avg_sh_q;   // {bcd, binary} double-dabble shift registers
    logic [SHW-1:0]   cnt_sh_q;

    logic [DW-1:0]    avg_bin_q;
    logic [BW-1:0]    avg_bcd_q;
    logic [BW-1:0]    cnt_bcd_q;
    logic             div0_out_q;
    logic             busy_q;
    logic             done_q;

    logic             close_c;
    logic [DW:0]      rem_sh_c;
    logic             ge_c;
    logic [DW-1:0]    rem_nx_c;
    logic [DW-1:0]    q_nx_c;
    logic [DW-1:0]    q_fin_c;

    assign close_c     = en_d & ~bus.en;
    assign bus.avg_bin = avg_bin_q;
    assign bus.avg_bcd = avg_bcd_q;
    assign bus.cnt_bcd = cnt_bcd_q;
    assign bus.div0    = div0_out_q;
    assign bus.busy    = busy_q;
    assign bus.done    = done_q;

    // One double-dabble step: correct nibbles >= 5, then shift left.
    function automatic logic [SHW-1:0] dabble(input logic [SHW-1:0] x);
        logic [SHW-1:0] y;
        y = x;
        for (int i = 0; i < int'(BW / 4); i++) begin
            if (y[DW + 4*i +: 4] >= 4'd5) begin
                y[DW + 4*i +: 4] = y[DW + 4*i +: 4] + 4'd3;
            end
        end
        return {y[SHW-2:0], 1'b0};
    endfunction

    // One restoring-divide step plus the final zero-divisor / rounding fix-up.
    always_comb begin
        rem_sh_c = {rem_q, dvd_q[DW-1]};
        ge_c     = rem_sh_c >= {1'b0, dvs_q};
        rem_nx_c = ge_c ? DW'(rem_sh_c - {1'b0, dvs_q}) : rem_sh_c[DW-1:0];
        q_nx_c   = {dvd_q[DW-2:0], ge_c};
        q_fin_c  = q_nx_c;
        if (div0_q) begin
            q_fin_c = '0;
        end else if (ROUND && ({rem_nx_c, 1'b0} >= {1'b0, dvs_q})) begin
            q_fin_c = q_nx_c + DW'(1);
        end
    end

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_IDLE;
        else        state_q <= state_d;
    end

    // Next-state logic; edges on en are only looked at in IDLE.
    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (close_c) state_d = S_WAIT;
            S_WAIT:  if (cnt_q == SETTLE_LAST) state_d = S_DIV;
            S_DIV:   if (cnt_q == STEP_LAST) state_d = S_BCD;
            S_BCD:   if (cnt_q == STEP_LAST) state_d = S_DONE;
            S_DONE:  state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    // Datapath and output registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            en_d       <= 1'b1;
            cnt_q      <= '0;
            dvd_q      <= '0;
            dvs_q      <= '0;
            rem_q      <= '0;
            q_q        <= '0;
            div0_q     <= 1'b0;
            avg_sh_q   <= '0;
            cnt_sh_q   <= '0;
            avg_bin_q  <= '0;
            avg_bcd_q  <= '0;
            cnt_bcd_q  <= '0;
            div0_out_q <= 1'b0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            en_d   <= bus.en;
            busy_q <= (state_d != S_IDLE);
            done_q <= (state_q == S_DONE);
            case (state_q)
                S_IDLE: cnt_q <= '0;
                S_WAIT: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    if (cnt_q == SETTLE_LAST) begin
                        cnt_q  <= '0;
                        dvd_q  <= bus.sum_in;
                        dvs_q  <= bus.s_in;
                        div0_q <= (bus.s_in == '0);
                        rem_q  <= '0;
                    end
                end
                S_DIV: begin
                    cnt_q <= cnt_q + CNT_W'(1);
                    dvd_q <= q_nx_c;
                    rem_q <= rem_nx_c;
                    if (cnt_q == STEP_LAST) begin
                        cnt_q    <= '0;
                        q_q      <= q_fin_c;
                        avg_sh_q <= {{BW{1'b0}}, q_fin_c};
                        cnt_sh_q <= {{BW{1'b0}}, dvs_q};
                    end
                end
                S_BCD: begin
                    cnt_q    <= cnt_q + CNT_W'(1);
                    avg_sh_q <= dabble(avg_sh_q);
                    cnt_sh_q <= dabble(cnt_sh_q);
                end
                S_DONE: begin
                    cnt_q      <= '0;
                    avg_bin_q  <= q_q;
                    avg_bcd_q  <= avg_sh_q[SHW-1:DW];
                    cnt_bcd_q  <= cnt_sh_q[SHW-1:DW];
                    div0_out_q <= div0_q;
                end
                default: cnt_q <= '0;
            endcase
        end
    end
endmodule
